// File: rtl/rp_mult_arbiter.sv
// Round-robin arbiter that shares one reconfigurable-partition multiplier among NUM_REQ
// requesters, with a decouple handshake that parks and resets the partition for reconfiguration.
module rp_mult_arbiter #(
    parameter int unsigned NUM_REQ      = 4,
    parameter int unsigned ID_W         = 2,
    parameter int unsigned MULT_LATENCY = 1
) (
    input  logic                  Clk,
    input  logic                  Reset_n,
    input  logic [NUM_REQ-1:0]    req_valid,
    output logic [NUM_REQ-1:0]    req_ready,
    input  logic [32*NUM_REQ-1:0] req_a,
    input  logic [32*NUM_REQ-1:0] req_b,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [31:0]           resp_data,
    output logic [ID_W-1:0]       resp_id,
    input  logic                  decouple,
    output logic                  decouple_ack,
    output logic [31:0]           rp_ain,
    output logic [31:0]           rp_bin,
    input  logic [31:0]           rp_result,
    output logic                  rp_rst_n
);

    localparam int unsigned CNT_W = 4;

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    ptr_q, ptr_d;
    logic [ID_W-1:0]    id_q, id_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        rp_ain_q, rp_ain_d;
    logic [31:0]        rp_bin_q, rp_bin_d;
    logic [31:0]        resp_data_q, resp_data_d;
    logic [ID_W-1:0]    resp_id_q, resp_id_d;
    logic               resp_valid_q, resp_valid_d;
    logic               ack_q, ack_d;
    logic               rp_rst_n_q, rp_rst_n_d;
    logic               init_q;

    logic [NUM_REQ-1:0] req_rot;
    logic               grant_found;
    int unsigned        grant_off;
    int unsigned        grant_sum;
    logic [ID_W-1:0]    grant_idx;
    logic               grant_en;
    logic [31:0]        sel_a, sel_b;

    // Rotate so the search always starts at bit 0, then map the hit back to a requester index.
    always_comb begin : rr_scan
        req_rot     = NUM_REQ'({req_valid, req_valid} >> ptr_q);
        grant_found = 1'b0;
        grant_off   = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            if (!grant_found && req_rot[k]) begin
                grant_found = 1'b1;
                grant_off   = k;
            end
        end
        grant_sum = 32'(ptr_q) + grant_off;
        if (grant_sum >= NUM_REQ) begin
            grant_sum = grant_sum - NUM_REQ;
        end
        grant_idx = ID_W'(grant_sum);
    end

    // init_q keeps grants off until the first edge after reset release.
    assign grant_en = (state_q == StIdle) && init_q && !decouple && !ack_q && grant_found;

    always_comb begin : grant_sel
        sel_a     = '0;
        sel_b     = '0;
        req_ready = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (grant_idx == ID_W'(i)) begin
                sel_a        = req_a[32*i +: 32];
                sel_b        = req_b[32*i +: 32];
                req_ready[i] = grant_en;
            end
        end
    end

    always_comb begin : fsm
        state_d      = state_q;
        ptr_d        = ptr_q;
        id_d         = id_q;
        cnt_d        = cnt_q;
        rp_ain_d     = rp_ain_q;
        rp_bin_d     = rp_bin_q;
        resp_data_d  = resp_data_q;
        resp_id_d    = resp_id_q;
        resp_valid_d = resp_valid_q;
        ack_d        = ack_q;
        unique case (state_q)
            StIdle: begin
                ack_d = decouple;
                if (grant_en) begin
                    rp_ain_d = sel_a;
                    rp_bin_d = sel_b;
                    id_d     = grant_idx;
                    ptr_d    = (grant_idx == ID_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
                    cnt_d    = CNT_W'(MULT_LATENCY);
                    state_d  = StWait;
                end
            end
            StWait: begin
                if (cnt_q == '0) begin
                    resp_data_d  = rp_result;
                    resp_id_d    = id_q;
                    resp_valid_d = 1'b1;
                    state_d      = StResp;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            StResp: begin
                if (resp_ready) begin
                    resp_valid_d = 1'b0;
                    state_d      = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
        if (ack_d) begin
            rp_ain_d = '0;
            rp_bin_d = '0;
        end
        // Partition stays in reset for one extra edge after the ack drops.
        rp_rst_n_d = !ack_d && !ack_q;
    end

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state_q      <= StIdle;
            ptr_q        <= '0;
            id_q         <= '0;
            cnt_q        <= '0;
            rp_ain_q     <= '0;
            rp_bin_q     <= '0;
            resp_data_q  <= '0;
            resp_id_q    <= '0;
            resp_valid_q <= 1'b0;
            ack_q        <= 1'b0;
            rp_rst_n_q   <= 1'b0;
            init_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            ptr_q        <= ptr_d;
            id_q         <= id_d;
            cnt_q        <= cnt_d;
            rp_ain_q     <= rp_ain_d;
            rp_bin_q     <= rp_bin_d;
            resp_data_q  <= resp_data_d;
            resp_id_q    <= resp_id_d;
            resp_valid_q <= resp_valid_d;
            ack_q        <= ack_d;
            rp_rst_n_q   <= rp_rst_n_d;
            init_q       <= 1'b1;
        end
    end

    assign resp_valid   = resp_valid_q;
    assign resp_data    = resp_data_q;
    assign resp_id      = resp_id_q;
    assign decouple_ack = ack_q;
    assign rp_ain       = rp_ain_q;
    assign rp_bin       = rp_bin_q;
    assign rp_rst_n     = rp_rst_n_q;

endmodule
